// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - Uart receive handshake and FIFO read-side bundle (optional UART_RX_FIFO_PARITY_DROP_EN adds perr_count)
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Uart receiver handshake
  logic                  RxInterrupt;
  logic [DATA_WIDTH-1:0] ReceivedData;
  logic                  ParityError;
  logic                  ClearInterrupt;

  // Consumer side
  logic                  pop;
  logic [DATA_WIDTH:0]   fifo_data;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  clear_overflow;
`ifdef UART_RX_FIFO_PARITY_DROP_EN
  logic [7:0]            perr_count;
`endif

`ifdef UART_RX_FIFO_PARITY_DROP_EN
  // Buffer view
  modport slave (
    input  RxInterrupt, ReceivedData, ParityError, pop, clear_overflow,
    output ClearInterrupt, fifo_data, empty, full, count, overflow, perr_count
  );
  // Uart + consumer view
  modport master (
    output RxInterrupt, ReceivedData, ParityError, pop, clear_overflow,
    input  ClearInterrupt, fifo_data, empty, full, count, overflow, perr_count
  );
`else
  // Buffer view
  modport slave (
    input  RxInterrupt, ReceivedData, ParityError, pop, clear_overflow,
    output ClearInterrupt, fifo_data, empty, full, count, overflow
  );
  // Uart + consumer view
  modport master (
    output RxInterrupt, ReceivedData, ParityError, pop, clear_overflow,
    input  ClearInterrupt, fifo_data, empty, full, count, overflow
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - Uart receive capture FSM feeding a FWFT FIFO (optional UART_RX_FIFO_PARITY_DROP_EN)
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t          state;
  logic [WW-1:0]   hold;
  logic            clear_int;
  logic [WW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            is_full;
  logic            is_empty;
  logic            push_req;
  logic            do_push;
  logic            do_pop;
  logic            drop;
  logic [WW-1:0]   wr_word;
`ifdef UART_RX_FIFO_PARITY_DROP_EN
  logic [7:0]      perr_count;
  logic            perr_discard;
`endif

  assign is_full  = (count == CW'(DEPTH));
  assign is_empty = (count == '0);

`ifdef UART_RX_FIFO_PARITY_DROP_EN
  // Bytes flagged with a parity error are acknowledged but never stored.
  assign perr_discard = (state == CAPTURE) && hold[WW-1];
  assign push_req     = (state == CAPTURE) && !hold[WW-1];
  assign wr_word      = {1'b0, hold[DATA_WIDTH-1:0]};
`else
  assign push_req     = (state == CAPTURE);
  assign wr_word      = hold;
`endif

  // A pop on an empty FIFO is a no-op; a pop on a full FIFO frees the slot
  // for a push landing in the same cycle.
  assign do_pop  = bus.pop && !is_empty;
  assign do_push = push_req && (!is_full || do_pop);
  assign drop    = push_req && !do_push;

  // Capture FSM: latch the byte, push it, then hold the acknowledge until the
  // Uart drops RxInterrupt so each assertion yields exactly one byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold      <= '0;
      clear_int <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clear_int <= 1'b0;
          if (bus.RxInterrupt) begin
            hold  <= {bus.ParityError, bus.ReceivedData};
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          clear_int <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          if (!bus.RxInterrupt) begin
            clear_int <= 1'b0;
            state     <= IDLE;
          end else begin
            clear_int <= 1'b1;
          end
        end
        default: begin
          clear_int <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Pointers wrap naturally; count tracks occupancy so full and empty are unambiguous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (bus.clear_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_PARITY_DROP_EN
  // Saturating tally of bytes discarded for parity errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_count <= '0;
    end else if (perr_discard && (perr_count != 8'hFF)) begin
      perr_count <= perr_count + 8'd1;
    end
  end

  assign bus.perr_count = perr_count;
`endif

  assign bus.ClearInterrupt = clear_int;
  assign bus.fifo_data      = is_empty ? '0 : mem[rd_ptr];
  assign bus.empty          = is_empty;
  assign bus.full           = is_full;
  assign bus.count          = count;
  assign bus.overflow       = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic [8:0] exp_head;
    int         exp_count;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise RxInterrupt with a byte and advance to the ACK state (entry pushed).
  task automatic irq_start(input logic [7:0] d, input logic p);
    bus.RxInterrupt  = 1'b1;
    bus.ReceivedData = d;
    bus.ParityError  = p;
    tick();
    chk("ci_low_in_capture", 32'(bus.ClearInterrupt), 32'd0);
    tick();
    chk("ci_high_in_ack", 32'(bus.ClearInterrupt), 32'd1);
  endtask

  // Drop RxInterrupt and let the FSM return to IDLE.
  task automatic irq_end();
    bus.RxInterrupt = 1'b0;
    tick();
    chk("ci_low_after_drop", 32'(bus.ClearInterrupt), 32'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic p);
    irq_start(d, p);
    irq_end();
  endtask

  task automatic pop_one();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
  endtask

  initial begin
    bus.RxInterrupt    = 1'b0;
    bus.ReceivedData   = '0;
    bus.ParityError    = 1'b0;
    bus.pop            = 1'b0;
    bus.clear_overflow = 1'b0;
    reset              = 1'b0;

    vecs[0] = '{data: 8'hA5, perr: 1'b0, exp_head: 9'h0A5, exp_count: 1};
    vecs[1] = '{data: 8'h00, perr: 1'b0, exp_head: 9'h000, exp_count: 1};
    vecs[2] = '{data: 8'hFF, perr: 1'b0, exp_head: 9'h0FF, exp_count: 1};
`ifdef UART_RX_FIFO_PARITY_DROP_EN
    vecs[3] = '{data: 8'h3C, perr: 1'b1, exp_head: 9'h000, exp_count: 0};
    vecs[4] = '{data: 8'h5A, perr: 1'b1, exp_head: 9'h000, exp_count: 0};
`else
    vecs[3] = '{data: 8'h3C, perr: 1'b1, exp_head: 9'h13C, exp_count: 1};
    vecs[4] = '{data: 8'h5A, perr: 1'b1, exp_head: 9'h15A, exp_count: 1};
`endif
    vecs[5] = '{data: 8'h81, perr: 1'b0, exp_head: 9'h081, exp_count: 1};

    repeat (2) tick();

    // Reset state
    chk("rst_ci",       32'(bus.ClearInterrupt), 32'd0);
    chk("rst_count",    32'(bus.count),          32'd0);
    chk("rst_empty",    32'(bus.empty),          32'd1);
    chk("rst_full",     32'(bus.full),           32'd0);
    chk("rst_overflow", 32'(bus.overflow),       32'd0);
    chk("rst_data",     32'(bus.fifo_data),      32'd0);
    reset = 1'b1;
    tick();

    // Single-byte vectors, each captured, inspected and drained
    for (int i = 0; i < 6; i++) begin
      irq_start(vecs[i].data, vecs[i].perr);
      chk($sformatf("vec%0d_count", i), 32'(bus.count),     32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_head", i),  32'(bus.fifo_data), 32'(vecs[i].exp_head));
      irq_end();
      if (vecs[i].exp_count != 0) pop_one();
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'd1);
    end
`ifdef UART_RX_FIFO_PARITY_DROP_EN
    chk("perr_count", 32'(bus.perr_count), 32'd2);
`endif

    // Pop on empty is ignored; next push reads back cleanly
    bus.pop = 1'b1;
    repeat (3) tick();
    bus.pop = 1'b0;
    chk("popempty_count", 32'(bus.count), 32'd0);
    chk("popempty_empty", 32'(bus.empty), 32'd1);
    send(8'h81, 1'b0);
    chk("popempty_head",  32'(bus.fifo_data), 32'h081);
    chk("popempty_count1", 32'(bus.count),    32'd1);
    pop_one();

    // Fill, overflow, in-order drain across pointer wrap, clear overflow
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0);
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    send(8'hFF, 1'b0);
    chk("ovf_set",   32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count),    32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), 32'(bus.fifo_data), 32'(i));
      pop_one();
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("ovf_sticky",  32'(bus.overflow), 32'd1);
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Full FIFO with pop on the CAPTURE cycle: push accepted, no overflow
    for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i), 1'b0);
    chk("fp_full", 32'(bus.full), 32'd1);
    bus.RxInterrupt  = 1'b1;
    bus.ReceivedData = 8'h55;
    bus.ParityError  = 1'b0;
    tick();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    chk("fp_count",    32'(bus.count),    32'd16);
    chk("fp_overflow", 32'(bus.overflow), 32'd0);
    chk("fp_ci",       32'(bus.ClearInterrupt), 32'd1);
    irq_end();
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("fp_drain%0d", i), 32'(bus.fifo_data), 32'(8'h10 + i));
      pop_one();
    end
    chk("fp_last", 32'(bus.fifo_data), 32'h055);
    pop_one();
    chk("fp_empty", 32'(bus.empty), 32'd1);

    // Asynchronous reset in the middle of ACK, then re-capture of pending byte
    irq_start(8'hC3, 1'b0);
    chk("mid_count", 32'(bus.count), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ci",       32'(bus.ClearInterrupt), 32'd0);
    chk("arst_count",    32'(bus.count),          32'd0);
    chk("arst_empty",    32'(bus.empty),          32'd1);
    chk("arst_overflow", 32'(bus.overflow),       32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("recap_ci",    32'(bus.ClearInterrupt), 32'd1);
    chk("recap_count", 32'(bus.count),          32'd1);
    chk("recap_head",  32'(bus.fifo_data),      32'h0C3);
    irq_end();
    pop_one();
    chk("final_empty", 32'(bus.empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
